// File: rtl/key_debouncer_pkg.sv
// Shared types and default timing for the push-button debouncer.
// The channel state enum lives here so the top, the channel and any consumer agree on it.
package key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam int unsigned DEF_NUM_KEYS     = 3;
    localparam int unsigned DEF_DEBOUNCE_CYC = 240000;
    localparam int unsigned DEF_LONG_CYC     = 6000000;
    localparam int unsigned DEF_REPEAT_CYC   = 1200000;

    // Bits needed to hold every value from 0 up to max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_debouncer_if.sv
// Key event bundle: raw active-low key levels in, debounced level and event pulses out.
// The slave side is the debouncer; the master side drives the buttons and consumes events.
interface key_debouncer_if #(
    parameter int W = 1
);
    logic [W-1:0] key_n;
    logic [W-1:0] level;
    logic [W-1:0] press_p;
    logic [W-1:0] release_p;
    logic [W-1:0] long_p;
    logic [W-1:0] repeat_p;

    modport master (
        output key_n,
        input  level, press_p, release_p, long_p, repeat_p
    );

    modport slave (
        input  key_n,
        output level, press_p, release_p, long_p, repeat_p
    );
endinterface

// File: rtl/key_debouncer_channel.sv
// One push-button channel: 2-flop synchronizer, debounce FSM, long-press and auto-repeat timing.
// state           | meaning
// ST_IDLE         | key released and stable
// ST_PRESS_WAIT   | key seen pressed, waiting for DEBOUNCE_CYC stable cycles
// ST_HELD         | press accepted, hold/repeat timing running
// ST_RELEASE_WAIT | key seen released, waiting for DEBOUNCE_CYC stable cycles
module key_channel
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned LONG_CYC     = DEF_LONG_CYC,
    parameter int unsigned REPEAT_CYC   = DEF_REPEAT_CYC
) (
    input logic            i_clk,
    input logic            i_rst_n,
    key_debouncer_if.slave bus
);

    localparam int unsigned HOLD_MAX = LONG_CYC + REPEAT_CYC - 1;
    localparam int DW = cnt_width(DEBOUNCE_CYC - 1);
    localparam int HW = cnt_width(HOLD_MAX);
    localparam int RW = cnt_width(REPEAT_CYC - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          s;
    key_state_t    state_q, state_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [RW-1:0] rep_q, rep_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          repeat_q, repeat_d;

    assign s = ~sync2_q;

    always_comb begin
        sync1_d   = bus.key_n[0];
        sync2_d   = sync1_q;
        state_d   = state_q;
        db_cnt_d  = db_cnt_q;
        hold_d    = hold_q;
        rep_d     = rep_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s) begin
                    state_d  = ST_PRESS_WAIT;
                    db_cnt_d = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!s) begin
                    state_d = ST_IDLE;
                end else if (db_cnt_q == DW'(DEBOUNCE_CYC - 1)) begin
                    state_d = ST_HELD;
                    press_d = 1'b1;
                    level_d = 1'b1;
                    hold_d  = '0;
                    rep_d   = '0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            ST_HELD: begin
                if (!s) begin
                    state_d  = ST_RELEASE_WAIT;
                    db_cnt_d = '0;
                end else begin
                    if (hold_q != HW'(HOLD_MAX))
                        hold_d = hold_q + 1'b1;
                    // Repeat timing only starts once the long-press point has passed.
                    if (hold_q == HW'(LONG_CYC - 1)) begin
                        long_d = 1'b1;
                        rep_d  = '0;
                    end else if (hold_q >= HW'(LONG_CYC)) begin
                        if (rep_q == RW'(REPEAT_CYC - 1)) begin
                            repeat_d = 1'b1;
                            rep_d    = '0;
                        end else begin
                            rep_d = rep_q + 1'b1;
                        end
                    end
                end
            end
            ST_RELEASE_WAIT: begin
                // Hold and repeat counts are frozen here so a short bounce resumes timing.
                if (s) begin
                    state_d = ST_HELD;
                end else if (db_cnt_q == DW'(DEBOUNCE_CYC - 1)) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= ST_IDLE;
            db_cnt_q  <= '0;
            hold_q    <= '0;
            rep_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            db_cnt_q  <= db_cnt_d;
            hold_q    <= hold_d;
            rep_q     <= rep_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
        end
    end

    assign bus.level     = level_q;
    assign bus.press_p   = press_q;
    assign bus.release_p = release_q;
    assign bus.long_p    = long_q;
    assign bus.repeat_p  = repeat_q;

endmodule

// File: rtl/key_debouncer.sv
// Multi-key push-button debouncer: one independent key_channel per button.
// Outputs are active-high events; inputs are raw active-low button levels.
module key_debouncer
    import key_pkg::*;
#(
    parameter int unsigned NUM_KEYS     = DEF_NUM_KEYS,
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned LONG_CYC     = DEF_LONG_CYC,
    parameter int unsigned REPEAT_CYC   = DEF_REPEAT_CYC
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NUM_KEYS-1:0] i_key_n,
    output logic [NUM_KEYS-1:0] o_level,
    output logic [NUM_KEYS-1:0] o_press,
    output logic [NUM_KEYS-1:0] o_release,
    output logic [NUM_KEYS-1:0] o_long,
    output logic [NUM_KEYS-1:0] o_repeat
);

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debouncer_if #(.W(1)) u_if ();

        assign u_if.key_n = i_key_n[g];

        key_channel #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .LONG_CYC     (LONG_CYC),
            .REPEAT_CYC   (REPEAT_CYC)
        ) u_ch (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .bus     (u_if.slave)
        );

        assign o_level[g]   = u_if.level[0];
        assign o_press[g]   = u_if.press_p[0];
        assign o_release[g] = u_if.release_p[0];
        assign o_long[g]    = u_if.long_p[0];
        assign o_repeat[g]  = u_if.repeat_p[0];
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: directed scenarios plus random key activity against a run-length model.
module tb_key_debouncer;

    localparam int N = 3;
    localparam int D = 4;
    localparam int L = 16;
    localparam int R = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    key_debouncer_if #(.W(N)) kif ();

    key_debouncer #(
        .NUM_KEYS     (N),
        .DEBOUNCE_CYC (D),
        .LONG_CYC     (L),
        .REPEAT_CYC   (R)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_key_n   (kif.key_n),
        .o_level   (kif.level),
        .o_press   (kif.press_p),
        .o_release (kif.release_p),
        .o_long    (kif.long_p),
        .o_repeat  (kif.repeat_p)
    );

    int total = 0;
    int bad   = 0;

    // Model: raw input delayed two edges, then a key flips only after D+1 consecutive
    // opposite observations; hold time counts observed-pressed cycles while stable.
    logic [N-1:0] m_p1, m_p2, m_lvl;
    logic [N-1:0] e_press, e_rel, e_long, e_rep;
    int           m_run  [N];
    int           m_held [N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_p1    = '1;
        m_p2    = '1;
        m_lvl   = '0;
        e_press = '0;
        e_rel   = '0;
        e_long  = '0;
        e_rep   = '0;
        for (int k = 0; k < N; k++) begin
            m_run[k]  = 0;
            m_held[k] = 0;
        end
    endtask

    task automatic model_step(input logic [N-1:0] kn);
        logic s;
        e_press = '0;
        e_rel   = '0;
        e_long  = '0;
        e_rep   = '0;
        for (int k = 0; k < N; k++) begin
            s = ~m_p2[k];
            if (s != m_lvl[k]) begin
                m_run[k]++;
                if (m_run[k] == D + 1) begin
                    m_lvl[k] = s;
                    m_run[k] = 0;
                    if (s) begin
                        e_press[k] = 1'b1;
                        m_held[k]  = 0;
                    end else begin
                        e_rel[k] = 1'b1;
                    end
                end
            end else begin
                if (m_lvl[k] && m_run[k] == 0) begin
                    m_held[k]++;
                    if (m_held[k] == L) e_long[k] = 1'b1;
                    if (m_held[k] > L && (m_held[k] - L) % R == 0) e_rep[k] = 1'b1;
                end
                m_run[k] = 0;
            end
        end
        m_p2 = m_p1;
        m_p1 = kn;
    endtask

    task automatic compare_all();
        chk("level",   32'(kif.level),     32'(m_lvl));
        chk("press",   32'(kif.press_p),   32'(e_press));
        chk("release", 32'(kif.release_p), 32'(e_rel));
        chk("long",    32'(kif.long_p),    32'(e_long));
        chk("repeat",  32'(kif.repeat_p),  32'(e_rep));
    endtask

    // Called 1 time unit after a rising edge; drives inputs, then advances one edge.
    task automatic cycle(input logic [N-1:0] kn);
        kif.key_n = kn;
        @(posedge clk);
        if (rst_n) model_step(kn);
        else       model_reset();
        #1;
        compare_all();
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
    endtask

    int n, cnt_a, cnt_b, long_cnt, rep_cnt, long_at, rel_cnt;
    int rep_at [2];
    logic found;
    logic [N-1:0] rk;
    int dur [N];

    initial begin
        rst_n     = 1'b0;
        kif.key_n = '1;
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        cycle('1);
        cycle('1);
        rst_n = 1'b1;
        cycle('1);

        // Short glitch on key0 must be rejected.
        cnt_a = 0;
        for (int i = 0; i < 3; i++) begin cycle(3'b110); cnt_a += int'(kif.press_p[0]); end
        for (int i = 0; i < 10; i++) begin cycle(3'b111); cnt_a += int'(kif.press_p[0]); end
        chk("glitch_press", 32'(cnt_a), 32'd0);
        chk("glitch_level", 32'(kif.level[0]), 32'd0);

        // Steady press: counted edges include the first sampling edge.
        n = 0; found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(3'b110); n++;
            if (kif.press_p[0]) found = 1'b1;
        end
        chk("press_lat", 32'(n), 32'(D + 3));
        chk("press_level", 32'(kif.level[0]), 32'd1);
        for (int i = 0; i < 5; i++) cycle(3'b110);
        n = 0; found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(3'b111); n++;
            if (kif.release_p[0]) found = 1'b1;
        end
        chk("release_lat", 32'(n), 32'(D + 3));
        chk("release_level", 32'(kif.level[0]), 32'd0);
        for (int i = 0; i < 4; i++) cycle(3'b111);

        // Long press and auto-repeat on key1.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(3'b101);
            if (kif.press_p[1]) found = 1'b1;
        end
        chk("k1_press_seen", 32'(found), 32'd1);
        long_cnt = 0; rep_cnt = 0; long_at = -1; rel_cnt = 0;
        rep_at[0] = -1; rep_at[1] = -1;
        for (int i = 1; i <= 52; i++) begin
            cycle(i <= 36 ? 3'b101 : 3'b111);
            if (kif.long_p[1]) begin long_cnt++; long_at = i; end
            if (kif.repeat_p[1]) begin
                if (rep_cnt < 2) rep_at[rep_cnt] = i;
                rep_cnt++;
            end
            if (kif.release_p[1]) rel_cnt++;
        end
        chk("long_cnt", 32'(long_cnt), 32'd1);
        chk("long_at",  32'(long_at),  32'(L));
        chk("rep_cnt",  32'(rep_cnt),  32'd2);
        chk("rep_at0",  32'(rep_at[0]), 32'(L + R));
        chk("rep_at1",  32'(rep_at[1]), 32'(L + 2 * R));
        chk("k1_rel_cnt", 32'(rel_cnt), 32'd1);

        // Bounce while held on key2: no release, no second press.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(3'b011);
            if (kif.press_p[2]) found = 1'b1;
        end
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 27; i++) begin
            cycle((i >= 5 && i < 7) ? 3'b111 : 3'b011);
            cnt_a += int'(kif.release_p[2]);
            cnt_b += int'(kif.press_p[2]);
        end
        chk("bounce_rel", 32'(cnt_a), 32'd0);
        chk("bounce_press", 32'(cnt_b), 32'd0);
        chk("bounce_level", 32'(kif.level[2]), 32'd1);
        for (int i = 0; i < 15; i++) cycle(3'b111);

        // Keys 0 and 2 together.
        n = 0; found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(3'b010); n++;
            if (kif.press_p != '0) found = 1'b1;
        end
        chk("sim_press", 32'(kif.press_p), 32'b101);
        chk("sim_lat", 32'(n), 32'(D + 3));
        for (int i = 0; i < 15; i++) cycle(3'b111);

        // Reset mid-hold with key0 still down, then a fresh press after reset.
        for (int i = 0; i < 20; i++) cycle(3'b110);
        chk("pre_rst_level", 32'(kif.level[0]), 32'd1);
        assert_reset();
        chk("rst_level", 32'(kif.level), 32'd0);
        for (int i = 0; i < 3; i++) cycle(3'b110);
        rst_n = 1'b1;
        n = 0; found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(3'b110); n++;
            if (kif.press_p[0]) found = 1'b1;
        end
        chk("rst_press_lat", 32'(n), 32'(D + 3));
        for (int i = 0; i < 15; i++) cycle(3'b111);

        // Random key activity with occasional resets.
        rk = '1;
        for (int k = 0; k < N; k++) dur[k] = $urandom_range(1, 20);
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                dur[k]--;
                if (dur[k] <= 0) begin
                    rk[k]  = ~rk[k];
                    dur[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4)
                                                         : $urandom_range(5, 40);
                end
            end
            if ($urandom_range(0, 599) == 0) begin
                assert_reset();
                cycle(rk);
                rst_n = 1'b1;
            end
            cycle(rk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
